bit_length_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 64-bit single-cycle length unit. Returns the bit length
//  (MSB index+1) or leading-zero count of a WIDTH-bit operand. Valid/ready in and out, 1 op/cycle.

---
 rtl/bit_length_pipe_pkg.sv | 14 +
 rtl/bit_length_chunk.sv | 22 ++
 rtl/bit_length_pipe.sv | 113 +++++++++++
 tb/tb_bit_length_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_length_pipe_pkg.sv
// Shared constants and helpers for the pipelined bit-length / leading-zero-count unit.
package bit_length_pipe_pkg;

    localparam logic MODE_LEN = 1'b0;
    localparam logic MODE_LZC = 1'b1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/bit_length_chunk.sv
// Combinational per-chunk priority encoder: non-zero flag and local bit length (0..CHUNK).
// Zero latency, no flow control.
module bit_length_chunk
    import bit_length_pipe_pkg::*;
#(
    parameter int CHUNK = 8,
    parameter int LOC_W = clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] chunk_i,
    output logic             nz_o,
    output logic [LOC_W-1:0] loc_o
);

    always_comb begin
        loc_o = '0;
        for (int b = 0; b < CHUNK; b++) begin
            if (chunk_i[b]) loc_o = LOC_W'(b + 1);
        end
        nz_o = |chunk_i;
    end

endmodule

// File: rtl/bit_length_pipe.sv
// Bit length / leading-zero count of a WIDTH-bit operand; 2-stage pipe, result 2 edges after accept.
// Valid/ready both sides; in_ready follows out_ready combinationally so a full pipe streams without bubbles.
module bit_length_pipe
    import bit_length_pipe_pkg::*;
#(
    parameter int   WIDTH = 64,
    parameter int   CHUNK = 8,
    localparam int  LEN_W = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] out_len,
    output logic             out_zero,
    output logic             out_mode
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int LOC_W = clog2(CHUNK + 1);

    logic                       s1_en;
    logic                       s2_en;

    logic [NCH-1:0]             nz_d;
    logic [NCH-1:0][LOC_W-1:0]  loc_d;

    logic                       s1_valid_q;
    logic                       s1_mode_q;
    logic [NCH-1:0]             s1_nz_q;
    logic [NCH-1:0][LOC_W-1:0]  s1_loc_q;

    logic [LEN_W-1:0]           raw_len;
    logic [LEN_W-1:0]           len_d;
    logic                       zero_d;

    logic                       s2_valid_q;
    logic [LEN_W-1:0]           len_q;
    logic                       zero_q;
    logic                       mode_q;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        bit_length_chunk #(
            .CHUNK (CHUNK),
            .LOC_W (LOC_W)
        ) u_chunk (
            .chunk_i (in_num[g*CHUNK +: CHUNK]),
            .nz_o    (nz_d[g]),
            .loc_o   (loc_d[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
        end
    end

    // Stage-1 payload needs no reset: it is only ever consumed alongside s1_valid_q.
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_nz_q   <= nz_d;
            s1_loc_q  <= loc_d;
            s1_mode_q <= in_mode;
        end
    end

    // Highest non-zero chunk wins; later iterations overwrite earlier ones.
    always_comb begin
        raw_len = '0;
        for (int c = 0; c < NCH; c++) begin
            if (s1_nz_q[c]) raw_len = LEN_W'(c * CHUNK) + LEN_W'(s1_loc_q[c]);
        end
        zero_d = ~|s1_nz_q;
        len_d  = raw_len;
        case (s1_mode_q)
            MODE_LEN: len_d = raw_len;
            MODE_LZC: len_d = LEN_W'(WIDTH) - raw_len;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid_q <= 1'b0;
            len_q      <= '0;
            zero_q     <= 1'b0;
            mode_q     <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                len_q  <= len_d;
                zero_q <= zero_d;
                mode_q <= s1_mode_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_len   = len_q;
    assign out_zero  = zero_q;
    assign out_mode  = mode_q;

endmodule

// File: tb/tb_bit_length_pipe.sv
// Scoreboard bench: directed 64/8 instance plus a random-ready 32/4 sweep against a flat reference model.
module tb_bit_length_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;

    logic        a_in_valid, a_in_ready, a_in_mode;
    logic [63:0] a_in_num;
    logic        a_out_valid, a_out_ready, a_out_zero, a_out_mode;
    logic [6:0]  a_out_len;

    logic        b_in_valid, b_in_ready, b_in_mode;
    logic [31:0] b_in_num;
    logic        b_out_valid, b_out_ready, b_out_zero, b_out_mode;
    logic [5:0]  b_out_len;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [15:0] hold_a, hold_b;
    logic [15:0] obs_a, obs_b;
    logic        sweep_done;

    assign obs_a = {7'd0, a_out_zero, a_out_mode, a_out_len};
    assign obs_b = {7'd0, b_out_zero, b_out_mode, 1'b0, b_out_len};

    bit_length_pipe #(.WIDTH(64), .CHUNK(8)) u_dut_a (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_num    (a_in_num),
        .in_mode   (a_in_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_len   (a_out_len),
        .out_zero  (a_out_zero),
        .out_mode  (a_out_mode)
    );

    bit_length_pipe #(.WIDTH(32), .CHUNK(4)) u_dut_b (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_num    (b_in_num),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_len   (b_out_len),
        .out_zero  (b_out_zero),
        .out_mode  (b_out_mode)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {zero, mode, len} from a top-down scan of the operand.
    function automatic logic [15:0] model(input logic [63:0] num, input int width, input logic mode);
        int         len;
        logic [6:0] res;
        len = 0;
        for (int i = width - 1; i >= 0; i--) begin
            if (num[i]) begin
                len = i + 1;
                break;
            end
        end
        res = mode ? 7'(width - len) : 7'(len);
        return {7'd0, (len == 0), mode, res};
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            q_a.delete();
            stall_a = 1'b0;
        end else begin
            if (stall_a) check("a_hold", {a_out_valid, obs_a}, {1'b1, hold_a});
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) check("a_unexpected_out", a_out_valid, 0);
                else                 check("a_result", obs_a, q_a.pop_front());
            end
            if (a_in_valid && a_in_ready) q_a.push_back(model(a_in_num, 64, a_in_mode));
            stall_a = a_out_valid && !a_out_ready;
            hold_a  = obs_a;
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            q_b.delete();
            stall_b = 1'b0;
        end else begin
            if (stall_b) check("b_hold", {b_out_valid, obs_b}, {1'b1, hold_b});
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) check("b_unexpected_out", b_out_valid, 0);
                else                 check("b_result", obs_b, q_b.pop_front());
            end
            if (b_in_valid && b_in_ready) q_b.push_back(model({32'd0, b_in_num}, 32, b_in_mode));
            stall_b = b_out_valid && !b_out_ready;
            hold_b  = obs_b;
        end
    end

    task automatic drive_a(input logic [63:0] num, input logic mode);
        int t;
        a_in_num   = num;
        a_in_mode  = mode;
        a_in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (a_in_ready || t > 200) break;
            t++;
        end
        if (t > 200) check("a_accept_timeout", a_in_ready, 1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [31:0] num, input logic mode);
        int t;
        b_in_num   = num;
        b_in_mode  = mode;
        b_in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (b_in_ready || t > 200) break;
            t++;
        end
        if (t > 200) check("b_accept_timeout", b_in_ready, 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int t;
        t = 0;
        while ((q_a.size() != 0 || a_out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("a_drained", q_a.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_b();
        int t;
        t = 0;
        while ((q_b.size() != 0 || b_out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("b_drained", q_b.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [63:0] tn[7];
    logic        tm[7];

    initial begin
        rstn        = 1'b0;
        a_in_valid  = 1'b0; a_in_num = '0; a_in_mode = 1'b0; a_out_ready = 1'b1;
        b_in_valid  = 1'b0; b_in_num = '0; b_in_mode = 1'b0; b_out_ready = 1'b1;
        sweep_done  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_len",   a_out_len,   0);
        check("rst_out_zero",  a_out_zero,  0);
        check("rst_out_mode",  a_out_mode,  0);
        check("rst_in_ready",  a_in_ready,  1);
        check("rst_b_valid",   b_out_valid, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Two-edge latency on an idle pipe.
        drive_a(64'h9, 1'b0);
        @(negedge clk);
        check("lat_after_1_edge", a_out_valid, 0);
        @(negedge clk);
        check("lat_after_2_edges", a_out_valid, 1);
        drain_a();

        tn = '{64'h9, 64'h9, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h1, 64'h1, 64'h0};
        tm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) drive_a(tn[i], tm[i]);
        drive_a(64'h0, 1'b1);
        drain_a();

        // Back-pressure: two ops fill the pipe, the third must wait.
        a_out_ready = 1'b0;
        fork
            begin
                drive_a(64'h1, 1'b0);
                drive_a(64'hFF, 1'b0);
                @(negedge clk);
                check("full_in_ready", a_in_ready, 0);
                drive_a(64'h100, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        drain_a();

        // Reset with both stages full must drop everything in flight.
        a_out_ready = 1'b0;
        drive_a(64'h3, 1'b0);
        drive_a(64'h5, 1'b1);
        check("pre_rst_full", {a_out_valid, a_in_ready}, 2'b10);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn        = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", a_out_valid, 0);
        check("mid_rst_out_len",   a_out_len,   0);
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", a_out_valid, 0);
        end
        @(posedge clk);
        #1;

        fork
            begin
                logic [31:0] num;
                for (int i = 0; i < 10000; i++) begin
                    if (i < 32)       num = 32'd1 << i;
                    else if (i == 32) num = 32'd0;
                    else              num = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    drive_b(num, 1'($urandom_range(0, 1)));
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk);
                    #1 b_out_ready = ($urandom_range(0, 3) != 0);
                end
                b_out_ready = 1'b1;
            end
        join
        drain_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
